// File: rtl/p405s_srm_pkg.sv
// Shared encodings and helpers for the SRM mask-generation stage.
// Optional self-check support is used when P405S_SRM_MSKCHK_EN is defined.
package p405s_srm_pkg;

    localparam int MSK_W = 32;
    localparam int HALF  = 16;

    typedef enum logic [1:0] {
        SRM_OP_RLW  = 2'b00,
        SRM_OP_SLW  = 2'b01,
        SRM_OP_SRW  = 2'b10,
        SRM_OP_ONES = 2'b11
    } srmOp_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOADED = 2'b01,
        ST_HELD   = 2'b10
    } srmState_e;

    typedef struct packed {
        logic [0:31] mskBegin;
        logic [0:14] mskEndHi;
        logic [0:14] mskEndLo;
        logic [0:1]  propLookAhd;
    } srmEnc_t;

    // Same carry chain the propagation stage builds: bit 16 takes its carry from lookahead[1].
    function automatic logic [0:31] srmPropagate(srmEnc_t e);
        logic [0:31] endFull;
        logic [0:31] m;
        logic        c;
        endFull = {e.mskEndHi, 1'b0, e.mskEndLo, 1'b0};
        m = '0;
        c = e.propLookAhd[0];
        for (int i = 0; i < MSK_W; i++) begin
            if (i == HALF) c = e.propLookAhd[1];
            m[i] = c | e.mskBegin[i];
            c = m[i] & ~endFull[i];
        end
        return m;
    endfunction

    function automatic logic [0:31] srmRangeMask(logic [4:0] mb, logic [4:0] me, logic empty);
        logic [0:31] m;
        m = '0;
        for (int i = 0; i < MSK_W; i++) begin
            if (!empty) begin
                if (mb <= me) m[i] = (5'(i) >= mb) && (5'(i) <= me);
                else          m[i] = (5'(i) >= mb) || (5'(i) <= me);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/p405s_srm_msk_gen_if.sv
// Execute-control to mask-generation bundle; mskChkErr exists only with P405S_SRM_MSKCHK_EN.
interface p405s_srm_msk_gen_if;

    logic        exeValid;
    logic        exeHold;
    logic        exeFlush;
    logic [1:0]  opType;
    logic [0:4]  mbField;
    logic [0:4]  meField;
    logic [0:5]  shAmt;
    logic [0:31] mskBegin;
    logic [0:14] mskEndHi;
    logic [16:30] mskEndLo;
    logic [0:1]  propLookAhd;
    logic        mskValid;
    logic        genBusy;
`ifdef P405S_SRM_MSKCHK_EN
    logic        mskChkErr;
`endif

    modport master (
`ifdef P405S_SRM_MSKCHK_EN
        input  mskChkErr,
`endif
        output exeValid, exeHold, exeFlush, opType, mbField, meField, shAmt,
        input  mskBegin, mskEndHi, mskEndLo, propLookAhd, mskValid, genBusy
    );

    modport slave (
`ifdef P405S_SRM_MSKCHK_EN
        output mskChkErr,
`endif
        input  exeValid, exeHold, exeFlush, opType, mbField, meField, shAmt,
        output mskBegin, mskEndHi, mskEndLo, propLookAhd, mskValid, genBusy
    );

endinterface

// File: rtl/p405s_srm_dec5to32.sv
// 5-bit index to 32-bit one-hot, big-endian bit numbering, all zero when disabled.
module p405s_srm_dec5to32 (
    input  logic        en,
    input  logic [4:0]  idx,
    output logic [0:31] oneHot
);

    assign oneHot = en ? (32'h8000_0000 >> idx) : '0;

endmodule

// File: rtl/p405s_srm_msk_gen.sv
// SRM mask-generation stage: resolves MB/ME, encodes begin/end/lookahead, registers it.
// Defining P405S_SRM_MSKCHK_EN adds the mskChkErr range-compare cross-check.
//
// state     | meaning
// ST_IDLE   | no live mask; waiting for exeValid
// ST_LOADED | live mask on outputs; may reload back-to-back
// ST_HELD   | execute stall; outputs frozen, inputs ignored
module p405s_srm_msk_gen
    import p405s_srm_pkg::*;
(
    input  logic                CB,
    input  logic                resetCore,
    p405s_srm_msk_gen_if.slave  srmIf
);

    localparam logic [4:0] LAST_HI = 5'(HALF - 1);

    logic [4:0]  effMb;
    logic [4:0]  effMe;
    logic        empty;
    logic [0:31] begOh;
    logic [0:31] endOh;
    logic [1:0]  unusedEndBits;
    logic        wrap;
    logic        in15;
    srmEnc_t     encNxt;
    srmEnc_t     encReg;
    srmState_e   state;
    srmState_e   stateNxt;
    logic        load;
    logic        clr;

    always_comb begin
        effMb = srmIf.mbField;
        effMe = srmIf.meField;
        empty = 1'b0;
        case (srmOp_e'(srmIf.opType))
            SRM_OP_SLW: begin
                empty = srmIf.shAmt[0];
                effMb = 5'd0;
                effMe = 5'd31 - srmIf.shAmt[1:5];
            end
            SRM_OP_SRW: begin
                empty = srmIf.shAmt[0];
                effMb = srmIf.shAmt[1:5];
                effMe = 5'd31;
            end
            SRM_OP_ONES: begin
                effMb = 5'd0;
                effMe = 5'd31;
            end
            default: ;
        endcase
    end

    p405s_srm_dec5to32 u_decBegin (.en(~empty), .idx(effMb), .oneHot(begOh));
    p405s_srm_dec5to32 u_decEnd   (.en(~empty), .idx(effMe), .oneHot(endOh));

    // ME at 15 or 31 is carried purely by the lookahead bits.
    assign unusedEndBits = {endOh[15], endOh[31]};

    assign wrap = effMb > effMe;
    assign in15 = wrap ? ((effMb <= LAST_HI) || (effMe >= LAST_HI))
                       : ((effMb <= LAST_HI) && (effMe >= LAST_HI));

    always_comb begin
        encNxt.mskBegin    = begOh;
        encNxt.mskEndHi    = endOh[0:14];
        encNxt.mskEndLo    = endOh[16:30];
        encNxt.propLookAhd = empty ? 2'b00 : {wrap, in15 && (effMe != LAST_HI)};
    end

    always_ff @(posedge CB) begin
        if (resetCore) state <= ST_IDLE;
        else           state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        load     = 1'b0;
        clr      = 1'b0;
        if (srmIf.exeFlush) begin
            stateNxt = ST_IDLE;
            clr      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (srmIf.exeValid) begin
                        load     = 1'b1;
                        stateNxt = ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    if (srmIf.exeHold)       stateNxt = ST_HELD;
                    else if (srmIf.exeValid) load = 1'b1;
                    else                     stateNxt = ST_IDLE;
                end
                ST_HELD: begin
                    if (!srmIf.exeHold) begin
                        stateNxt = ST_LOADED;
                        load     = srmIf.exeValid;
                    end
                end
                default: stateNxt = ST_IDLE;
            endcase
        end
    end

    // Vectors keep their last value on LOADED->IDLE; only flush and reset clear them.
    always_ff @(posedge CB) begin
        if (resetCore)  encReg <= '0;
        else if (clr)   encReg <= '0;
        else if (load)  encReg <= encNxt;
    end

    assign srmIf.mskBegin    = encReg.mskBegin;
    assign srmIf.mskEndHi    = encReg.mskEndHi;
    assign srmIf.mskEndLo    = encReg.mskEndLo;
    assign srmIf.propLookAhd = encReg.propLookAhd;
    assign srmIf.mskValid    = (state != ST_IDLE);
    assign srmIf.genBusy     = (state == ST_HELD);

`ifdef P405S_SRM_MSKCHK_EN
    logic chkErr;

    always_ff @(posedge CB) begin
        if (resetCore) chkErr <= 1'b0;
        else           chkErr <= load && (srmPropagate(encNxt) != srmRangeMask(effMb, effMe, empty));
    end

    assign srmIf.mskChkErr = chkErr;
`endif

endmodule
